// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for PC-addressed fetch requests
//
// Holds the program in a word array. It returns one instruction per request
// after WAIT_STATES extra cycles. It faults misaligned or out-of-range PCs, and
// a load port preloads the program while no fetch is in flight.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_req, i_addr    fetch request and byte address (held while o_busy=1)
//   i_kill           redirect: abort the outstanding access
//   o_inst           returned instruction, valid with o_inst_valid
//   o_inst_valid     one-cycle response strobe
//   o_inst_fault     with o_inst_valid: misaligned or out-of-range address
//   o_busy           stall to the fetch stage
//   i_load_en/addr/data  program-load write port
//   o_load_drop      pulses when a load arrives during an access
module imem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    input  logic              i_kill,
    output logic [31:0]       o_inst,
    output logic              o_inst_valid,
    output logic              o_inst_fault,
    output logic              o_busy,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [31:0]       i_load_data,
    output logic              o_load_drop
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_inst;
    logic              r_fault;
    logic              r_load_drop;
    logic [31:0]       r_mem [2**ADDR_W];

    logic [ADDR_W-1:0] w_idx;
    logic              w_fault;
    logic              w_accept;

    assign w_idx    = i_addr[ADDR_W+1:2];
    assign w_fault  = (i_addr[1:0] != 2'b00) || ((i_addr >> (ADDR_W + 2)) != 32'd0);
    // Load has priority over req; in RESP a kill beats a simultaneous req.
    assign w_accept = i_req && !i_load_en &&
                      (r_state == S_IDLE || (r_state == S_RESP && !i_kill));

    assign o_inst       = r_inst;
    assign o_inst_fault = r_fault;
    assign o_inst_valid = (r_state == S_RESP) && !i_kill;
    assign o_busy       = (r_state == S_WAIT);
    assign o_load_drop  = r_load_drop;

    // Program array: never reset, written only while no access is in flight.
    always_ff @(posedge clk) begin
        if (i_load_en && r_state == S_IDLE)
            r_mem[i_load_addr] <= i_load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_inst      <= '0;
            r_fault     <= 1'b0;
            r_load_drop <= 1'b0;
        end else begin
            r_load_drop <= i_load_en && (r_state != S_IDLE);
            if (w_accept) begin
                r_idx <= w_idx;
                if (w_fault) begin
                    r_state <= S_RESP;
                    r_inst  <= '0;
                    r_fault <= 1'b1;
                end else if (WAIT_STATES == 0) begin
                    r_state <= S_RESP;
                    r_inst  <= r_mem[w_idx];
                    r_fault <= 1'b0;
                end else begin
                    r_state <= S_WAIT;
                    r_cnt   <= CNT_INIT;
                end
            end else if (r_state == S_WAIT && !i_kill && r_cnt == 4'd0) begin
                r_state <= S_RESP;
                r_inst  <= r_mem[r_idx];
                r_fault <= 1'b0;
            end else if (r_state == S_WAIT && !i_kill) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed bench for imem_responder (ADDR_W=10, WAIT_STATES=2)
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, kill, load_en;
    logic [31:0] addr, load_data;
    logic [9:0]  load_addr;
    logic [31:0] inst;
    logic        inst_valid, inst_fault, busy, load_drop;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t_first;

    localparam logic [31:0] W4    = 32'h20080005;
    localparam logic [31:0] W5    = 32'h8c090000;
    localparam logic [31:0] W6    = 32'hcafef00d;
    localparam logic [31:0] WLAST = 32'hdeadbeef;

    imem_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_addr(addr), .i_kill(kill),
        .o_inst(inst), .o_inst_valid(inst_valid), .o_inst_fault(inst_fault),
        .o_busy(busy), .i_load_en(load_en), .i_load_addr(load_addr),
        .i_load_data(load_data), .o_load_drop(load_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick;
        load_en = 1'b0;
    endtask

    // Issue one request, count busy cycles until the response, then release req.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp,
                         input logic exp_f, input int exp_busy);
        int nb = 0;
        int n = 0;
        req = 1'b1; addr = a;
        tick;
        while (!inst_valid && n < 20) begin
            if (busy) nb++;
            tick;
            n++;
        end
        req = 1'b0;
        check({tag, "_valid"}, 32'(inst_valid), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        check({tag, "_inst"}, inst, exp);
        check({tag, "_fault"}, 32'(inst_fault), 32'(exp_f));
        tick;
        check({tag, "_valid_drop"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst_hold"}, inst, exp);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; kill = 1'b0; load_en = 1'b0;
        addr = '0; load_addr = '0; load_data = '0;
        tick; tick;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_fault", 32'(inst_fault), 32'd0);
        check("rst_drop", 32'(load_drop), 32'd0);
        rst_n = 1'b1;
        tick;

        load(10'd4, W4);
        load(10'd5, W5);
        load(10'd1023, WLAST);
        check("idle_load_drop", 32'(load_drop), 32'd0);

        fetch("t1", 32'h10, W4, 1'b0, 2);
        fetch("t2_misalign", 32'h12, 32'd0, 1'b1, 0);
        fetch("t3_range", 32'h1000, 32'd0, 1'b1, 0);
        fetch("top_word", 32'hffc, WLAST, 1'b0, 2);
        fetch("high_bit", 32'h8000_0010, 32'd0, 1'b1, 0);

        // kill one cycle into WAIT
        req = 1'b1; addr = 32'h10;
        tick;
        check("t4_busy", 32'(busy), 32'd1);
        kill = 1'b1; req = 1'b0;
        tick;
        kill = 1'b0;
        check("t4_busy_drop", 32'(busy), 32'd0);
        check("t4_no_valid", 32'(inst_valid), 32'd0);
        tick; tick; tick;
        check("t4_no_late_valid", 32'(inst_valid), 32'd0);
        fetch("t4_after", 32'h14, W5, 1'b0, 2);

        // kill in RESP masks the strobe and beats a held req
        req = 1'b1; addr = 32'h10;
        tick; tick; tick;
        kill = 1'b1;
        #1;
        check("kresp_masked", 32'(inst_valid), 32'd0);
        tick;
        kill = 1'b0; req = 1'b0;
        check("kresp_not_accepted", 32'(busy), 32'd0);
        tick;

        // kill in IDLE is ignored and the redirect req is accepted
        req = 1'b1; addr = 32'h14; kill = 1'b1;
        tick;
        kill = 1'b0;
        check("kidle_accept", 32'(busy), 32'd1);
        tick; tick;
        req = 1'b0;
        check("kidle_valid", 32'(inst_valid), 32'd1);
        check("kidle_inst", inst, W5);
        tick;

        // back-to-back: second req presented in the RESP cycle
        req = 1'b1; addr = 32'h10;
        tick; tick; tick;
        check("b2b_first_valid", 32'(inst_valid), 32'd1);
        check("b2b_first_inst", inst, W4);
        t_first = cyc;
        addr = 32'h14;
        tick;
        check("b2b_second_busy", 32'(busy), 32'd1);
        tick; tick;
        req = 1'b0;
        check("b2b_second_valid", 32'(inst_valid), 32'd1);
        check("b2b_second_inst", inst, W5);
        check("b2b_spacing", 32'(cyc - t_first), 32'd3);
        tick;

        // load during WAIT is dropped
        req = 1'b1; addr = 32'h10;
        tick;
        load_en = 1'b1; load_addr = 10'd4; load_data = 32'h11111111;
        tick;
        load_en = 1'b0;
        check("t6_drop_pulse", 32'(load_drop), 32'd1);
        tick;
        req = 1'b0;
        check("t6_drop_clear", 32'(load_drop), 32'd0);
        check("t6_valid", 32'(inst_valid), 32'd1);
        check("t6_word_kept", inst, W4);
        tick;
        fetch("t6_refetch", 32'h10, W4, 1'b0, 2);

        // load beats req in IDLE
        req = 1'b1; addr = 32'h14; load_en = 1'b1; load_addr = 10'd6; load_data = W6;
        tick;
        req = 1'b0; load_en = 1'b0;
        check("load_prio_no_accept", 32'(busy), 32'd0);
        check("load_prio_no_drop", 32'(load_drop), 32'd0);
        fetch("load_prio_word", 32'h18, W6, 1'b0, 2);

        // async reset mid-WAIT
        req = 1'b1; addr = 32'h10;
        tick;
        check("rstw_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_busy_low", 32'(busy), 32'd0);
        check("rstw_valid_low", 32'(inst_valid), 32'd0);
        req = 1'b0;
        tick;
        rst_n = 1'b1;
        begin
            int pulses = 0;
            for (int i = 0; i < 6; i++) begin
                tick;
                if (inst_valid || busy) pulses++;
            end
            check("rstw_no_response", 32'(pulses), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
